// File: rtl/rom_port_arbiter_if.sv
// Requester-side read port of the ROM arbiter: request/grant plus a valid/ready response.
// The master modport belongs to the requester (fetch or load unit), slave to the arbiter.
interface rom_port_arbiter_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             req;
  logic [WIDTH-1:0] addr;
  logic             gnt;
  logic             rvalid;
  logic [WIDTH-1:0] rdata;
  logic             rready;
  logic             rerr;

  modport master (
    output req,
    output addr,
    output rready,
    input  gnt,
    input  rvalid,
    input  rdata,
    input  rerr
  );

  modport slave (
    input  req,
    input  addr,
    input  rready,
    output gnt,
    output rvalid,
    output rdata,
    output rerr
  );

endinterface

// File: rtl/rom_port_arbiter.sv
// Two-port (fetch/load) arbiter for a single-port asynchronous ROM, D-priority with I anti-starvation.
// Optional range/alignment checking is compiled in with `define ROM_ADDR_CHECK_EN.
module rom_port_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 2048,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  rom_port_arbiter_if.slave       i_port,
  rom_port_arbiter_if.slave       d_port,
  output logic [WIDTH-1:0]        rom_address,
  input  logic [WIDTH-1:0]        rom_rdata
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_WAIT);

  if (MAX_WAIT < 1 || DEPTH < 1) begin : g_param_check
    $error("rom_port_arbiter: MAX_WAIT and DEPTH must both be at least 1");
  end

  typedef enum logic {StIdle, StResp} state_e;
  typedef enum logic {OwnI, OwnD} owner_e;

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [CntW-1:0]  starve_q, starve_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             err_q, err_d;

  logic free;
  logic force_i;
  logic i_gnt, d_gnt;
  logic i_own, d_own;

`ifdef ROM_ADDR_CHECK_EN
  function automatic logic addr_err(input logic [WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[WIDTH-1:2]} >= WIDTH'(DEPTH));
  endfunction
`endif

  assign i_own = (state_q == StResp) && (owner_q == OwnI);
  assign d_own = (state_q == StResp) && (owner_q == OwnD);

  // The slot frees up in the same cycle the current owner consumes its response.
  assign free    = (state_q == StIdle) || (i_own && i_port.rready) || (d_own && d_port.rready);
  assign force_i = (starve_q == CntMax);

  // Grants are suppressed while reset is asserted so no request is accepted and then lost.
  assign d_gnt = !reset && free && d_port.req && !(force_i && i_port.req);
  assign i_gnt = !reset && free && i_port.req && !d_gnt;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    err_d   = err_q;
    if (free) begin
      if (d_gnt) begin
        state_d = StResp;
        owner_d = OwnD;
        addr_d  = d_port.addr;
`ifdef ROM_ADDR_CHECK_EN
        err_d   = addr_err(d_port.addr);
`endif
      end else if (i_gnt) begin
        state_d = StResp;
        owner_d = OwnI;
        addr_d  = i_port.addr;
`ifdef ROM_ADDR_CHECK_EN
        err_d   = addr_err(i_port.addr);
`endif
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    starve_d = '0;
    if (i_port.req && !i_gnt) begin
      starve_d = force_i ? starve_q : starve_q + CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= OwnI;
      starve_q <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

  assign rom_address = addr_q;

  always_comb begin
    i_port.gnt    = i_gnt;
    d_port.gnt    = d_gnt;
    i_port.rvalid = i_own;
    d_port.rvalid = d_own;
    i_port.rdata  = '0;
    d_port.rdata  = '0;
    i_port.rerr   = 1'b0;
    d_port.rerr   = 1'b0;
`ifdef ROM_ADDR_CHECK_EN
    if (i_own) begin
      i_port.rerr  = err_q;
      i_port.rdata = err_q ? '0 : rom_rdata;
    end
    if (d_own) begin
      d_port.rerr  = err_q;
      d_port.rdata = err_q ? '0 : rom_rdata;
    end
`else
    if (i_own) i_port.rdata = rom_rdata;
    if (d_own) d_port.rdata = rom_rdata;
`endif
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: per-cycle grant/valid checks plus a response scoreboard.
module tb_rom_port_arbiter;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rom_address;
  logic [31:0] rom_rdata;
  logic [31:0] mem [2048];

  int n_vec = 0;
  int n_err = 0;
  exp_t iq[$];
  exp_t dq[$];
  logic [31:0] held;

  rom_port_arbiter_if #(.WIDTH(32)) i_if ();
  rom_port_arbiter_if #(.WIDTH(32)) d_if ();

  rom_port_arbiter #(.WIDTH(32), .DEPTH(2048), .MAX_WAIT(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_port      (i_if),
    .d_port      (d_if),
    .rom_address (rom_address),
    .rom_rdata   (rom_rdata)
  );

  always #5 clock = ~clock;

  assign rom_rdata = mem[rom_address[12:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t exp_of(input logic [31:0] a);
    exp_t e;
`ifdef ROM_ADDR_CHECK_EN
    e.err = (a[1:0] != 2'b00) || (a[31:2] >= 30'd2048);
`else
    e.err = 1'b0;
`endif
    e.data = e.err ? 32'h0 : mem[a[12:2]];
    return e;
  endfunction

  // Scoreboard: check held responses every valid cycle, retire on handshake, enqueue on grant.
  always @(negedge clock) begin
    if (reset) begin
      iq.delete();
      dq.delete();
    end else begin
      if (i_if.rvalid) begin
        if (iq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL i_unexpected_rvalid: got rvalid=1 required no response");
        end else begin
          chk("i_sb_rdata", i_if.rdata, iq[0].data);
          chk("i_sb_rerr", {31'b0, i_if.rerr}, {31'b0, iq[0].err});
          if (i_if.rready) void'(iq.pop_front());
        end
      end
      if (d_if.rvalid) begin
        if (dq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL d_unexpected_rvalid: got rvalid=1 required no response");
        end else begin
          chk("d_sb_rdata", d_if.rdata, dq[0].data);
          chk("d_sb_rerr", {31'b0, d_if.rerr}, {31'b0, dq[0].err});
          if (d_if.rready) void'(dq.pop_front());
        end
      end
      if (i_if.gnt) iq.push_back(exp_of(i_if.addr));
      if (d_if.gnt) dq.push_back(exp_of(d_if.addr));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic gnts(input string name, input logic ei, input logic ed);
    chk({name, "_i_gnt"}, {31'b0, i_if.gnt}, {31'b0, ei});
    chk({name, "_d_gnt"}, {31'b0, d_if.gnt}, {31'b0, ed});
  endtask

  task automatic vals(input string name, input logic ei, input logic ed);
    chk({name, "_i_rvalid"}, {31'b0, i_if.rvalid}, {31'b0, ei});
    chk({name, "_d_rvalid"}, {31'b0, d_if.rvalid}, {31'b0, ed});
  endtask

  initial begin
    for (int k = 0; k < 2048; k++) mem[k] = {16'hC0DE, 16'(k)};
    mem[4] = 32'h00500093;
    i_if.req = 1'b0; i_if.addr = '0; i_if.rready = 1'b1;
    d_if.req = 1'b0; d_if.addr = '0; d_if.rready = 1'b1;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    mid();
    vals("rst", 1'b0, 1'b0);
    gnts("rst", 1'b0, 1'b0);
    chk("rst_rom_address", rom_address, 32'h0);
    chk("rst_i_rdata", i_if.rdata, 32'h0);
    chk("rst_d_rdata", d_if.rdata, 32'h0);
    tick();

    // Single fetch
    i_if.req = 1'b1; i_if.addr = 32'h10;
    mid(); gnts("fetch", 1'b1, 1'b0);
    tick(); i_if.req = 1'b0;
    mid(); vals("fetch_resp", 1'b1, 1'b0);
    chk("fetch_rdata", i_if.rdata, 32'h00500093);
    chk("fetch_rom_address", rom_address, 32'h10);
    tick();
    mid(); vals("fetch_done", 1'b0, 1'b0);
    tick();

    // Simultaneous requests: D first, I right behind with no bubble
    i_if.req = 1'b1; i_if.addr = 32'h0;
    d_if.req = 1'b1; d_if.addr = 32'h20;
    mid(); gnts("sim0", 1'b0, 1'b1);
    tick(); d_if.req = 1'b0;
    mid(); gnts("sim1", 1'b1, 1'b0); vals("sim1", 1'b0, 1'b1);
    chk("sim1_d_rdata", d_if.rdata, 32'hC0DE0008);
    tick(); i_if.req = 1'b0;
    mid(); vals("sim2", 1'b1, 1'b0);
    chk("sim2_i_rdata", i_if.rdata, 32'hC0DE0000);
    tick();
    mid(); vals("sim3", 1'b0, 1'b0);
    tick();

    // Starvation: I is force-granted on its 5th requesting cycle
    i_if.req = 1'b1; i_if.addr = 32'h44;
    d_if.req = 1'b1; d_if.addr = 32'h40;
    for (int c = 1; c <= 6; c++) begin
      mid(); gnts($sformatf("starve%0d", c), c == 5, c != 5);
      tick();
      if (c == 5) i_if.req = 1'b0;
    end
    d_if.req = 1'b0;
    tick(); tick();

    // Backpressure: D response held while I waits
    d_if.req = 1'b1; d_if.addr = 32'h80; d_if.rready = 1'b0;
    mid(); gnts("bp0", 1'b0, 1'b1);
    tick(); d_if.req = 1'b0; i_if.req = 1'b1; i_if.addr = 32'h84;
    for (int c = 1; c <= 3; c++) begin
      mid();
      gnts($sformatf("bp%0d", c), 1'b0, 1'b0);
      chk($sformatf("bp%0d_d_rvalid", c), {31'b0, d_if.rvalid}, 32'h1);
      chk($sformatf("bp%0d_d_rdata", c), d_if.rdata, 32'hC0DE0020);
      tick();
    end
    d_if.rready = 1'b1;
    mid(); gnts("bp4", 1'b1, 1'b0); vals("bp4", 1'b0, 1'b1);
    tick(); i_if.req = 1'b0;
    mid(); vals("bp5", 1'b1, 1'b0);
    chk("bp5_i_rdata", i_if.rdata, 32'hC0DE0021);
    tick(); tick();

    // Reset mid-transaction
    i_if.req = 1'b1; i_if.addr = 32'h8; i_if.rready = 1'b0;
    mid(); gnts("rmid0", 1'b1, 1'b0);
    tick();
    mid(); vals("rmid1", 1'b1, 1'b0); gnts("rmid1", 1'b0, 1'b0);
    tick(); reset = 1'b1; i_if.req = 1'b0;
    mid(); chk("rmid2_starve", 32'(dut.starve_q), 32'h1);
    gnts("rmid2", 1'b0, 1'b0);
    tick(); reset = 1'b0; i_if.rready = 1'b1;
    mid(); vals("rmid3", 1'b0, 1'b0);
    chk("rmid3_rom_address", rom_address, 32'h0);
    chk("rmid3_starve", 32'(dut.starve_q), 32'h0);
    tick();

    // Out-of-range / misaligned load addresses
    d_if.req = 1'b1; d_if.addr = 32'h2002;
    mid(); gnts("chk0", 1'b0, 1'b1);
    tick(); d_if.addr = 32'h2000;
    mid(); gnts("chk1", 1'b0, 1'b1); vals("chk1", 1'b0, 1'b1);
`ifdef ROM_ADDR_CHECK_EN
    chk("chk1_d_rerr", {31'b0, d_if.rerr}, 32'h1);
    chk("chk1_d_rdata", d_if.rdata, 32'h0);
`else
    chk("chk1_d_rerr", {31'b0, d_if.rerr}, 32'h0);
    chk("chk1_d_rdata", d_if.rdata, 32'hC0DE0000);
`endif
    tick(); d_if.req = 1'b0;
    mid(); vals("chk2", 1'b0, 1'b1);
`ifdef ROM_ADDR_CHECK_EN
    chk("chk2_d_rerr", {31'b0, d_if.rerr}, 32'h1);
    chk("chk2_d_rdata", d_if.rdata, 32'h0);
`else
    chk("chk2_d_rerr", {31'b0, d_if.rerr}, 32'h0);
    chk("chk2_d_rdata", d_if.rdata, 32'hC0DE0000);
`endif
    tick(); tick();

    mid();
    chk("drain_iq", iq.size(), 32'h0);
    chk("drain_dq", dq.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
